// File: rtl/omsp_spm_key_writer_if.sv
// Key-write bundle between the key source, the key writer and SPM control.
// master: key source / SPM-control side; slave: the key writer itself.
`ifndef SECURITY
`define SECURITY 64
`endif

interface omsp_spm_key_writer_if #(
  parameter int KEY_IDX_SIZE = 2
);
  logic                    start;
  logic [0:`SECURITY-1]    key_src;
  logic                    violation;
  logic                    write_key;
  logic [15:0]             key_in;
  logic [KEY_IDX_SIZE-1:0] key_idx;
  logic                    busy;
  logic                    done;
  logic                    aborted;

  modport master (
    output start, key_src, violation,
    input  write_key, key_in, key_idx, busy, done, aborted
  );

  modport slave (
    input  start, key_src, violation,
    output write_key, key_in, key_idx, busy, done, aborted
  );
endinterface

// File: rtl/omsp_spm_key_writer.sv
// Streams a captured SECURITY-bit key into SPM control as 16-bit words.
// Define OMSP_SPM_KEY_WIPE_EN to zero-fill all key words after a violation.
`ifndef SECURITY
`define SECURITY 64
`endif

module omsp_spm_key_writer #(
  parameter int KEY_IDX_SIZE = 2
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  omsp_spm_key_writer_if.slave kw
);

  localparam int SECURITY = `SECURITY;
  localparam int N        = SECURITY / 16;
  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1
`ifdef OMSP_SPM_KEY_WIPE_EN
    ,
    ST_WIPE  = 2'd2
`endif
  } state_t;

  state_t                  state;
  logic [0:SECURITY-1]     shadow;
  logic [KEY_IDX_SIZE-1:0] idx;
  logic                    done_r;
  logic                    aborted_r;
  logic [15:0]             cur_word;

  // Word 0 sits at the MSB end of the key (bit 0 is the MSB).
  assign cur_word = shadow[{idx, 4'b0000} +: 16];

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      idx       <= '0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (kw.start) begin
            shadow <= kw.key_src;
            idx    <= '0;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (kw.violation) begin
            shadow <= '0;
            idx    <= '0;
`ifdef OMSP_SPM_KEY_WIPE_EN
            state  <= ST_WIPE;
`else
            state     <= ST_IDLE;
            aborted_r <= 1'b1;
`endif
          end else if (idx == LAST_IDX) begin
            shadow <= '0;
            idx    <= '0;
            state  <= ST_IDLE;
            done_r <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`ifdef OMSP_SPM_KEY_WIPE_EN
        ST_WIPE: begin
          // Violation no longer gates writes here: every slot must be zeroed.
          if (idx == LAST_IDX) begin
            idx       <= '0;
            state     <= ST_IDLE;
            aborted_r <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        default: begin
          shadow <= '0;
          idx    <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Write gating on violation is combinational so a violating cycle never writes.
  always_comb begin
    kw.write_key = 1'b0;
    kw.key_in    = 16'h0000;
    kw.key_idx   = '0;
    case (state)
      ST_WRITE: begin
        kw.write_key = ~kw.violation;
        kw.key_in    = cur_word;
        kw.key_idx   = idx;
      end
`ifdef OMSP_SPM_KEY_WIPE_EN
      ST_WIPE: begin
        kw.write_key = 1'b1;
        kw.key_in    = 16'h0000;
        kw.key_idx   = idx;
      end
`endif
      default: begin
        kw.write_key = 1'b0;
        kw.key_in    = 16'h0000;
        kw.key_idx   = '0;
      end
    endcase
  end

  assign kw.busy    = (state != ST_IDLE);
  assign kw.done    = done_r;
  assign kw.aborted = aborted_r;

endmodule

// File: tb/tb_omsp_spm_key_writer.sv
// Scoreboard bench for omsp_spm_key_writer: transaction-level model predicts
// every write, busy cycle and done/aborted pulse with its cycle number.
`ifndef SECURITY
`define SECURITY 64
`endif

module tb_omsp_spm_key_writer;

  localparam int SEC = `SECURITY;
  localparam int N   = SEC / 16;
  localparam int KIS = 2;

  logic mclk    = 1'b0;
  logic puc_rst = 1'b1;
  always #5 mclk = ~mclk;

  omsp_spm_key_writer_if #(.KEY_IDX_SIZE(KIS)) kw();

  omsp_spm_key_writer #(.KEY_IDX_SIZE(KIS)) dut (
    .mclk   (mclk),
    .puc_rst(puc_rst),
    .kw     (kw)
  );

  typedef struct { int cyc; int idx; logic [15:0] data; } wr_t;
  typedef struct { int cyc; bit is_done; } ev_t;

  wr_t wq[$];
  ev_t eq[$];
  bit  busy_exp [int];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [0:SEC-1] rand_key();
    logic [0:SEC-1] k;
    for (int i = 0; i < SEC; i += 32) k[i +: 32] = $urandom;
    return k;
  endfunction

  // Monitor: compares DUT outputs against the scoreboard queues mid-cycle.
  always @(negedge mclk) begin
    wr_t w;
    ev_t e;
    if (mon_en) begin
      chk("busy", kw.busy, busy_exp.exists(cyc) ? 1 : 0);
      chk("done_with_aborted", kw.done & kw.aborted, 0);
      if (!kw.busy) chk("idle_outputs", {kw.write_key, kw.key_in, kw.key_idx}, 0);

      if (kw.write_key) begin
        if (wq.size() == 0) chk("write_key", kw.write_key, 0);
        else begin
          w = wq.pop_front();
          chk("write_cycle", cyc, w.cyc);
          chk("write_idx", kw.key_idx, w.idx);
          chk("write_data", kw.key_in, w.data);
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        chk("write_key", kw.write_key, 1);
        void'(wq.pop_front());
      end

      if (kw.done || kw.aborted) begin
        if (eq.size() == 0) chk("event", {kw.done, kw.aborted}, 0);
        else begin
          e = eq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_kind", {kw.done, kw.aborted}, e.is_done ? 2'b10 : 2'b01);
          chk("shadow_cleared", dut.shadow, 0);
        end
      end else if (eq.size() != 0 && eq[0].cyc <= cyc) begin
        chk("event", {kw.done, kw.aborted}, eq[0].is_done ? 2'b10 : 2'b01);
        void'(eq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // voff: WRITE-cycle offset (0..N-1) of the violation, or -1 for none.
  task automatic run_txn(input logic [0:SEC-1] key, input int voff,
                         input bit hold, input bit spur);
    int  c0, k, ev, j;
    wr_t w;
    ev_t e;
    c0 = cyc;
    kw.start     = 1'b1;
    kw.key_src   = key;
    kw.violation = 1'b0;
    if (voff < 0) begin
      for (int i = 0; i < N; i++) begin
        w.cyc = c0 + 1 + i; w.idx = i; w.data = key[i*16 +: 16]; wq.push_back(w);
      end
      ev = c0 + N + 1;
      e.is_done = 1'b1;
    end else begin
      for (int i = 0; i < voff; i++) begin
        w.cyc = c0 + 1 + i; w.idx = i; w.data = key[i*16 +: 16]; wq.push_back(w);
      end
      k = c0 + 1 + voff;
`ifdef OMSP_SPM_KEY_WIPE_EN
      for (int i = 0; i < N; i++) begin
        w.cyc = k + 1 + i; w.idx = i; w.data = 16'h0000; wq.push_back(w);
      end
      ev = k + N + 1;
`else
      ev = k + 1;
`endif
      e.is_done = 1'b0;
    end
    e.cyc = ev;
    eq.push_back(e);
    for (int c = c0 + 1; c < ev; c++) busy_exp[c] = 1'b1;
    step();
    while (cyc < ev) begin
      j = cyc - c0 - 1;
      kw.start     = spur && ($urandom_range(0, 1) == 0);
      kw.key_src   = rand_key();
      kw.violation = (voff >= 0) && ((j == voff) || (hold && j > voff));
      step();
    end
    kw.start     = 1'b0;
    kw.violation = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      kw.start     = 1'b0;
      kw.key_src   = rand_key();
      kw.violation = $urandom_range(0, 1);
      step();
    end
    kw.violation = 1'b0;
  endtask

  task automatic reset_mid_write(input logic [0:SEC-1] key);
    int  c0;
    wr_t w;
    c0 = cyc;
    kw.start   = 1'b1;
    kw.key_src = key;
    for (int i = 0; i < 2; i++) begin
      w.cyc = c0 + 1 + i; w.idx = i; w.data = key[i*16 +: 16]; wq.push_back(w);
      busy_exp[c0 + 1 + i] = 1'b1;
    end
    step();
    kw.start = 1'b0;
    step();
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
    chk("shadow_after_reset", dut.shadow, 0);
  endtask

  initial begin
    int voff;
    kw.start     = 1'b0;
    kw.key_src   = '0;
    kw.violation = 1'b0;
    puc_rst      = 1'b1;
    repeat (2) step();
    mon_en = 1'b1;
    repeat (2) step();
    puc_rst = 1'b0;

    run_txn(64'h0123_4567_89AB_CDEF, -1, 1'b0, 1'b1);
    run_txn(64'hFFFF_0000_AAAA_5555, -1, 1'b0, 1'b0);
    idle_cycles(3);
    run_txn(64'h0123_4567_89AB_CDEF, 2, 1'b0, 1'b0);
    idle_cycles(2);
    run_txn(64'h0123_4567_89AB_CDEF, 2, 1'b1, 1'b1);
    idle_cycles(2);
    run_txn(64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0, 1'b0);
    run_txn(64'h1111_2222_3333_4444, N - 1, 1'b0, 1'b0);
    idle_cycles(2);
    reset_mid_write(64'h0123_4567_89AB_CDEF);
    idle_cycles(2);

    for (int t = 0; t < 40; t++) begin
      voff = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_txn(rand_key(), voff, $urandom_range(0, 1), $urandom_range(0, 1));
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    chk("writes_outstanding", wq.size(), 0);
    chk("events_outstanding", eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/omsp_spm_key_writer.md
# omsp_spm_key_writer

Sequencer that drives the key-write port of the SPM control block. It captures a `SECURITY`-bit module key, for example from key derivation, and streams it as 16-bit words using `write_key`, `key_in` and `key_idx`, one word per cycle. It aborts cleanly when the SPM control block raises `violation`. It sits between the crypto/key-derivation logic and the SPM array, inside the execution-unit clock domain.

## Interface
- `KEY_IDX_SIZE`, default 2: width of `key_idx`. Must satisfy 2^KEY_IDX_SIZE >= N, where N = `SECURITY`/16 (N=4 for `SECURITY`=64).

Ports:
- `mclk`  in  1  system clock; all state updates on the rising edge.
- `puc_rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  key-write request. Sampled only in IDLE.
- `key_src`  in  [0:`SECURITY-1]  key to write; bit 0 is the MSB. Captured on an accepted `start`.
- `violation`  in  1  violation from SPM control; aborts a WRITE sequence.
- `write_key`  out  1  key-word write strobe to SPM control.
- `key_in`  out  16  key word being written.
- `key_idx`  out  KEY_IDX_SIZE  word index being written.
- `busy`  out  1  sequence in progress (WRITE or WIPE).
- `done`  out  1  one-cycle pulse: all N words written.
- `aborted`  out  1  one-cycle pulse: sequence terminated by `violation`.

## Operation
- States: IDLE, WRITE, WIPE. WIPE exists only with the configuration macro defined.
- Internal registers: shadow key register (`SECURITY` bits), word counter `idx` (KEY_IDX_SIZE bits), `done` and `aborted` flags.
- IDLE:
  - `start`=1 loads the shadow key from `key_src`, sets `idx`=0 and moves to WRITE.
  - `start` in any other state is ignored and is not queued.
- WRITE:
  - `key_in` = shadow[idx*16 +: 16], so word 0 is `key_src` bits [0:15].
  - `key_idx` = idx.
  - `write_key` = ~`violation`. The gating is combinational, so a write is never issued in a violating cycle.
  - No violation and idx < N-1: increment idx.
  - No violation and idx == N-1: go to IDLE, clear the shadow key and set `done` for the next cycle.
  - `violation`=1: go to IDLE (or WIPE, see Configuration), clear the shadow key and set `aborted` for the next cycle when going to IDLE.
- Outside WRITE/WIPE: `write_key`=0, `key_in`=16'h0, `key_idx`=0.
- The shadow key is never retained after completion or abort.
- `busy` = (state != IDLE).
- Reset values: state IDLE, shadow 0, idx 0, and all outputs 0.
- Reset mid-sequence: the sequence is dropped immediately, with no `done` or `aborted` pulse and no further writes.
- Index arithmetic: idx never wraps. Terminal detection is idx == N-1, compared at KEY_IDX_SIZE width.

## Timing
- Cycle numbering: `start` is accepted at the end of cycle 0.
- Writes occur in cycles 1..N with idx 0..N-1.
- `busy` is high in cycles 1..N.
- `done` is high in cycle N+1 only.
- Total latency from start to done is N+1 cycles.
- `done`/`aborted` cycles are IDLE, so a new `start` in that cycle is accepted and writing resumes the following cycle. Back-to-back throughput is one key per N+1 cycles.
- `violation` in WRITE cycle k: no write in cycle k.
  - Without wipe: `aborted` is high in cycle k+1.
- `done` and `aborted` are never high in the same cycle.

## Configuration
- Macro: `OMSP_SPM_KEY_WIPE_EN`.
- Defined:
  - A violation in WRITE enters WIPE instead of IDLE.
  - WIPE writes 16'h0 to idx 0..N-1, one per cycle, with `write_key`=1 regardless of `violation`.
  - After idx N-1 the block goes to IDLE with `aborted` high the next cycle.
  - Abort latency from the violation cycle k is N+1 cycles (`aborted` in cycle k+N+1).
  - `busy` stays high throughout WIPE, and `start` is ignored.
- Undefined:
  - The WIPE state is not built.
  - Abort goes straight to IDLE with `aborted` in cycle k+1.
  - Partially written words remain in the SPM.

## Test plan
- Nominal write (`SECURITY`=64, `key_src`=64'h0123_4567_89AB_CDEF, `start` in cycle 0) -> writes 0123/4567/89AB/CDEF at idx 0/1/2/3 in cycles 1-4, `done` in cycle 5 only, then `key_in`=0 and the shadow key is cleared.
- Violation in cycle 3, no macro -> writes only idx 0 and 1; no write in cycle 3; `aborted` in cycle 4; `done` never asserted.
- Violation in cycle 3, `OMSP_SPM_KEY_WIPE_EN` defined -> zeros written to idx 0..3 in cycles 4-7 despite `violation` held high; `aborted` in cycle 8; `busy` high in cycles 1-7.
- `start` pulsed in cycles 2 and 3 during WRITE -> ignored and the key is unchanged. A second `start` in the `done` cycle (5) with key 64'hFFFF_0000_AAAA_5555 -> words written in cycles 6-9, `done` in cycle 10.
- `puc_rst` asserted in cycle 2 of a write -> from cycle 3, all outputs are 0, no `done`/`aborted`, and the shadow key reads 0.
- `violation` high while IDLE -> no outputs change and no `aborted` pulse.
